// File: rtl/add_sub_bcd_scan.sv
// Registered add/subtract, shift-add-3 BCD conversion and
// multiplexed active-low seven-segment scan.
module add_sub_bcd_scan #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 4,
  parameter int BLANK    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                busy,
  output logic                done,
  output logic                neg,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   an_n,
  output logic [6:0]          seg
);

  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N + 1);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("WIDTH must be 2..16");
  end
  if (pow10(DIGITS) <= (longint'(1) << N) - 1) begin : g_bad_digits
    $error("DIGITS too small for WIDTH");
  end
  if (SCAN_DIV < 1) begin : g_bad_div
    $error("SCAN_DIV must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t              st, st_nx;
  logic [N-1:0]        r, sh;
  logic [4*DIGITS-1:0] scr, adj;
  logic [CW-1:0]       cnt;
  logic                neg_nx;

  always_comb begin
    r = '0;
    if (!op)        r = {1'b0, a} + {1'b0, b};
    else if (a < b) r = {1'b0, b - a};
    else            r = {1'b0, a - b};
  end

  always_comb begin
    adj = scr;
    for (int i = 0; i < DIGITS; i++)
      if (scr[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (start) st_nx = CONV;
      CONV:    if (cnt == CW'(N - 1)) st_nx = COMMIT;
      COMMIT:  st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  assign busy = (st != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh     <= '0;
      scr    <= '0;
      cnt    <= '0;
      neg_nx <= 1'b0;
      bcd    <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE: if (start) begin
          sh     <= r;
          scr    <= '0;
          cnt    <= '0;
          neg_nx <= op && (a < b);
        end
        CONV: begin
          scr <= {adj[4*DIGITS-2:0], sh[N-1]};
          sh  <= sh << 1;
          cnt <= cnt + CW'(1);
        end
        COMMIT: begin
          bcd  <= scr;
          neg  <= neg_nx;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'h40;
      4'd1:    dec = 7'h79;
      4'd2:    dec = 7'h24;
      4'd3:    dec = 7'h30;
      4'd4:    dec = 7'h19;
      4'd5:    dec = 7'h12;
      4'd6:    dec = 7'h02;
      4'd7:    dec = 7'h78;
      4'd8:    dec = 7'h00;
      4'd9:    dec = 7'h10;
      default: dec = 7'h7F;
    endcase
  endfunction

  logic [SW-1:0] sc;
  logic [IW-1:0] idx;
  logic [3:0]    dig;
  logic          lz, blank;

  // lz walks down from the top digit: still all-zero so far
  always_comb begin
    dig   = '0;
    blank = 1'b0;
    lz    = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (idx == IW'(i)) dig = bcd[4*i +: 4];
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz = lz && (bcd[4*i +: 4] == 4'd0);
      if (idx == IW'(i)) blank = lz;
    end
    blank = blank && (BLANK != 0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc   <= '0;
      idx  <= '0;
      an_n <= '1;
      seg  <= 7'h7F;
    end else begin
      an_n <= ~(DIGITS'(1) << idx);
      seg  <= blank ? 7'h7F : dec(dig);
      if (sc == SW'(SCAN_DIV - 1)) begin
        sc  <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        sc <= sc + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_add_sub_bcd_scan.sv
// Randomised bench for add_sub_bcd_scan against an
// arithmetic reference model.
module tb_add_sub_bcd_scan;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int SD = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           op = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done, neg;
  logic [4*D-1:0] bcd;
  logic [D-1:0]   an_n;
  logic [6:0]     seg;

  int checks = 0;
  int errors = 0;

  logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  add_sub_bcd_scan #(
    .WIDTH(W), .DIGITS(D), .SCAN_DIV(SD), .BLANK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .neg(neg),
    .bcd(bcd), .an_n(an_n), .seg(seg)
  );

  function automatic int mres(input bit o, input int x, input int y);
    return o ? (x > y ? x - y : y - x) : x + y;
  endfunction

  function automatic logic [11:0] mbcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] mseg(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (i > 0 && v < p) return 7'h7F;
    return tbl[v / p % 10];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit o, input int x, input int y,
                        output int lat, output int nb);
    op = o; a = W'(x); b = W'(y); start = 1'b1;
    tick;
    start = 1'b0; lat = 0; nb = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) nb++;
      tick;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL rst_bcd got %h exp 000", bcd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL rst_neg got %b exp 0", neg); end
    checks++; if (an_n !== 3'b111) begin errors++; $display("FAIL rst_an got %b exp 111", an_n); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg got %h exp 7f", seg); end
    rst_n = 1'b1;
    tick;
    checks++; if (an_n !== 3'b110) begin errors++; $display("FAIL rst_an0 got %b exp 110", an_n); end
    checks++; if (seg !== 7'h40) begin errors++; $display("FAIL rst_seg0 got %h exp 40", seg); end
    repeat (4) tick;
    checks++; if (an_n !== 3'b101) begin errors++; $display("FAIL rst_an1 got %b exp 101", an_n); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg1 got %h exp 7f", seg); end
    repeat (4) tick;
    checks++; if (an_n !== 3'b011) begin errors++; $display("FAIL rst_an2 got %b exp 011", an_n); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg2 got %h exp 7f", seg); end
  endtask

  task automatic test_add;
    int lat, nb;
    run_op(1'b0, 15, 15, lat, nb);
    checks++; if (lat != W + 2) begin errors++; $display("FAIL add_lat got %0d exp %0d", lat, W + 2); end
    checks++; if (nb != W + 2) begin errors++; $display("FAIL add_busy got %0d exp %0d", nb, W + 2); end
    checks++; if (bcd !== 12'h030) begin errors++; $display("FAIL add_bcd got %h exp 030", bcd); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL add_neg got %b exp 0", neg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_idle got %b exp 0", busy); end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_pulse got %b exp 0", done); end
    run_op(1'b0, 255, 255, lat, nb);
    checks++; if (bcd !== 12'h510) begin errors++; $display("FAIL add_max got %h exp 510", bcd); end
  endtask

  task automatic test_sub;
    int lat, nb;
    run_op(1'b1, 3, 9, lat, nb);
    checks++; if (bcd !== 12'h006) begin errors++; $display("FAIL sub_lt_bcd got %h exp 006", bcd); end
    checks++; if (neg !== 1'b1) begin errors++; $display("FAIL sub_lt_neg got %b exp 1", neg); end
    run_op(1'b1, 9, 3, lat, nb);
    checks++; if (bcd !== 12'h006) begin errors++; $display("FAIL sub_gt_bcd got %h exp 006", bcd); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL sub_gt_neg got %b exp 0", neg); end
    run_op(1'b1, 200, 200, lat, nb);
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL sub_eq_bcd got %h exp 000", bcd); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL sub_eq_neg got %b exp 0", neg); end
  endtask

  task automatic test_handshake;
    int nd, first, d1, d2;
    op = 1'b0; a = 8'd20; b = 8'd30; start = 1'b1;
    tick;
    start = 1'b0; nd = 0; first = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3 || k == 7) begin
        start = 1'b1; op = 1'b1;
        a = W'($urandom); b = W'($urandom);
      end
      tick;
      start = 1'b0;
      if (done) begin nd++; if (first == 0) first = k; end
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL hs_count got %0d exp 1", nd); end
    checks++; if (first != W + 2) begin errors++; $display("FAIL hs_lat got %0d exp %0d", first, W + 2); end
    checks++; if (bcd !== mbcd(50)) begin errors++; $display("FAIL hs_bcd got %h exp %h", bcd, mbcd(50)); end
    op = 1'b0; a = 8'd1; b = 8'd2; start = 1'b1;
    tick;
    d1 = 0; d2 = 0;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (done) begin
        if (d1 == 0) begin
          d1 = k;
          checks++; if (bcd !== mbcd(3)) begin errors++; $display("FAIL b2b_bcd1 got %h exp %h", bcd, mbcd(3)); end
          a = 8'd100; b = 8'd23;
        end else begin
          d2 = k;
          start = 1'b0;
          checks++; if (bcd !== mbcd(123)) begin errors++; $display("FAIL b2b_bcd2 got %h exp %h", bcd, mbcd(123)); end
          break;
        end
      end
    end
    start = 1'b0;
    checks++; if (d1 != W + 2) begin errors++; $display("FAIL b2b_lat got %0d exp %0d", d1, W + 2); end
    checks++; if (d2 - d1 != W + 3) begin errors++; $display("FAIL b2b_gap got %0d exp %0d", d2 - d1, W + 3); end
    tick;
  endtask

  task automatic test_reset_mid;
    int nd, lat, nb;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    op = 1'b0; a = 8'd77; b = 8'd66; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL mid_bcd got %h exp 000", bcd); end
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      tick;
      if (done) nd++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL mid_done got %0d exp 0", nd); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL mid_hold got %h exp 000", bcd); end
    run_op(1'b1, 9, 3, lat, nb);
    checks++; if (lat != W + 2) begin errors++; $display("FAIL mid_lat got %0d exp %0d", lat, W + 2); end
    checks++; if (bcd !== 12'h006) begin errors++; $display("FAIL mid_after got %h exp 006", bcd); end
  endtask

  task automatic test_random;
    int lat, nb, x, y, v;
    bit o;
    for (int n = 0; n < 25; n++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      v = mres(o, x, y);
      run_op(o, x, y, lat, nb);
      checks++; if (lat != W + 2) begin errors++; $display("FAIL rnd_lat got %0d exp %0d", lat, W + 2); end
      checks++; if (bcd !== mbcd(v)) begin errors++; $display("FAIL rnd_bcd op=%0d a=%0d b=%0d got %h exp %h", o, x, y, bcd, mbcd(v)); end
      checks++; if (neg !== (o && x < y)) begin errors++; $display("FAIL rnd_neg got %b exp %b", neg, (o && x < y)); end
    end
  endtask

  task automatic test_scan(input int v);
    int lat, nb, i;
    bit ok;
    logic [2:0] ea;
    run_op(1'b0, v / 2, v - v / 2, lat, nb);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (an_n === 3'b011) begin ok = 1'b1; break; end
    end
    if (ok) begin
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        tick;
        if (an_n === 3'b110) begin ok = 1'b1; break; end
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL scan_sync got %b exp 110", an_n); end
    for (int k = 0; ok && k < 2 * D * SD; k++) begin
      i = (k / SD) % D;
      ea = ~(3'b001 << i);
      checks++; if (an_n !== ea) begin errors++; $display("FAIL scan_an v=%0d k=%0d got %b exp %b", v, k, an_n, ea); end
      checks++; if (seg !== mseg(v, i)) begin errors++; $display("FAIL scan_seg v=%0d k=%0d got %h exp %h", v, k, seg, mseg(v, i)); end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_handshake;
    test_reset_mid;
    test_random;
    test_scan(507);
    test_scan(7);
    test_scan(40);
    test_scan($urandom_range(0, 510));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
